mem_access_stage: RTL and testbench

- MEM stage of the 5-stage MIPS pipeline. Consumes the EX/MEM pipeline register outputs and runs loads and stores on a req/ack data-memory bus.
- Formats load data by size and sign. Produces the MEM/WB register contents.
- Asserts stall to freeze IF..EX/MEM while a memory transaction is outstanding.

---
 rtl/mips_pkg.sv | 36 +++
 rtl/mem_load_align.sv | 26 ++
 rtl/mem_access_stage.sv | 169 ++++++++++++++++
 tb/tb_mem_access_stage.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types: access-size encodings, MEM-stage FSM state,
// and the fields latched for an outstanding memory transaction.
package mips_pkg;

  localparam int REG_W = 5;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mem_state_t;

  typedef struct packed {
    logic             reg_write;
    logic             mem_to_reg;
    logic             is_load;
    logic             load_uns;
    logic [1:0]       size;
    logic [1:0]       addr_lo;
    logic [31:0]      alu;
    logic [REG_W-1:0] wreg;
  } mem_lat_t;

  // Reserved size 2'b11 falls into the word case.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lo[0];
      default: return |lo;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load formatter: picks the byte/half lane out of the read word and
// sign- or zero-extends it to 32 bits.
module mem_load_align
  import mips_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr_lo,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_size)
      SZ_BYTE: o_data = {{24{~i_unsigned & w_byte[7]}}, w_byte};
      SZ_HALF: o_data = {{16{~i_unsigned & w_half[15]}}, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: req/ack data-memory access, load formatting, MEM/WB register.
// Optional watchdog with bus_err output when MEM_TIMEOUT_EN is defined.
module mem_access_stage
  import mips_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWrite,
  input  logic              MemtoReg,
  input  logic              MemWrite,
  input  logic              MemRead,
  input  logic [1:0]        MemSize,
  input  logic              LoadUnsigned,
  input  logic [31:0]       ALUresult,
  input  logic [31:0]       writedata,
  input  logic [REG_W-1:0]  writeReg,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata,
`ifdef MEM_TIMEOUT_EN
  output logic              bus_err,
`endif
  output logic              stall,
  output logic              misalign,
  output logic              RegWriteOut,
  output logic              MemtoRegOut,
  output logic [31:0]       readdataOut,
  output logic [31:0]       ALUresultOut,
  output logic [REG_W-1:0]  writeRegOut
);

  mem_state_t  r_state;
  mem_lat_t    r_lat;
  logic        w_memop;
  logic        w_mis;
  logic        w_tmo;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_fmt;

  assign w_memop = MemRead | MemWrite;
  assign w_mis   = misaligned(MemSize, ALUresult[1:0]);

  always_comb begin
    case (MemSize)
      SZ_BYTE: begin
        w_be    = 4'b0001 << ALUresult[1:0];
        w_wdata = {4{writedata[7:0]}};
      end
      SZ_HALF: begin
        w_be    = 4'b0011 << {ALUresult[1], 1'b0};
        w_wdata = {2{writedata[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = writedata;
      end
    endcase
  end

  // The timeout cycle also drops stall so the stuck instruction retires as a bubble.
  assign stall = ((r_state == ST_IDLE) && w_memop && !w_mis) ||
                 ((r_state == ST_BUSY) && !dmem_ack && !w_tmo);

  mem_load_align u_align (
    .i_rdata    (dmem_rdata),
    .i_addr_lo  (r_lat.addr_lo),
    .i_size     (r_lat.size),
    .i_unsigned (r_lat.load_uns),
    .o_data     (w_fmt)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_cnt;

  assign w_tmo = (r_state == ST_BUSY) && !dmem_ack &&
                 (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || r_state != ST_BUSY || dmem_ack) r_cnt <= '0;
    else                                       r_cnt <= r_cnt + 1'b1;
    bus_err <= rst ? 1'b0 : w_tmo;
  end
`else
  // Watchdog compiled out: BUSY waits for ack indefinitely.
  assign w_tmo = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_lat        <= '0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_be      <= '0;
      dmem_wdata   <= '0;
      misalign     <= 1'b0;
      RegWriteOut  <= 1'b0;
      MemtoRegOut  <= 1'b0;
      readdataOut  <= '0;
      ALUresultOut <= '0;
      writeRegOut  <= '0;
    end else begin
      misalign <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!w_memop) begin
            RegWriteOut  <= RegWrite;
            MemtoRegOut  <= MemtoReg;
            ALUresultOut <= ALUresult;
            writeRegOut  <= writeReg;
          end else if (w_mis) begin
            misalign     <= 1'b1;
            RegWriteOut  <= 1'b0;
            MemtoRegOut  <= 1'b0;
            ALUresultOut <= ALUresult;
            writeRegOut  <= writeReg;
          end else begin
            r_state     <= ST_BUSY;
            dmem_req    <= 1'b1;
            dmem_we     <= MemWrite;
            dmem_addr   <= {ALUresult[ADDR_W-1:2], 2'b00};
            dmem_be     <= w_be;
            dmem_wdata  <= w_wdata;
            RegWriteOut <= 1'b0;
            MemtoRegOut <= 1'b0;
            r_lat       <= '{reg_write:  RegWrite,
                             mem_to_reg: MemtoReg,
                             is_load:    MemRead & ~MemWrite,
                             load_uns:   LoadUnsigned,
                             size:       MemSize,
                             addr_lo:    ALUresult[1:0],
                             alu:        ALUresult,
                             wreg:       writeReg};
          end
        end
        ST_BUSY: begin
          if (dmem_ack) begin
            r_state      <= ST_IDLE;
            dmem_req     <= 1'b0;
            RegWriteOut  <= r_lat.reg_write;
            MemtoRegOut  <= r_lat.mem_to_reg;
            ALUresultOut <= r_lat.alu;
            writeRegOut  <= r_lat.wreg;
            if (r_lat.is_load) readdataOut <= w_fmt;
          end else begin
            RegWriteOut <= 1'b0;
            MemtoRegOut <= 1'b0;
            if (w_tmo) begin
              r_state  <= ST_IDLE;
              dmem_req <= 1'b0;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed test-plan steps plus a
// randomized instruction stream checked against a byte-level reference model.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWrite, MemtoReg, MemWrite, MemRead, LoadUnsigned;
  logic [1:0]  MemSize;
  logic [31:0] ALUresult, writedata;
  logic [4:0]  writeReg;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        stall, misalign, RegWriteOut, MemtoRegOut;
  logic [31:0] readdataOut, ALUresultOut;
  logic [4:0]  writeRegOut;
`ifdef MEM_TIMEOUT_EN
  logic        bus_err;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_rd;

  mem_access_stage dut (
    .clk(clk), .rst(rst),
    .RegWrite(RegWrite), .MemtoReg(MemtoReg), .MemWrite(MemWrite), .MemRead(MemRead),
    .MemSize(MemSize), .LoadUnsigned(LoadUnsigned), .ALUresult(ALUresult),
    .writedata(writedata), .writeReg(writeReg),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
`ifdef MEM_TIMEOUT_EN
    .bus_err(bus_err),
`endif
    .stall(stall), .misalign(misalign),
    .RegWriteOut(RegWriteOut), .MemtoRegOut(MemtoRegOut), .readdataOut(readdataOut),
    .ALUresultOut(ALUresultOut), .writeRegOut(writeRegOut)
  );

  always #5 clk = ~clk;

  // ---- reference model: accesses as byte counts and byte offsets ----
  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic m_mis(input logic [1:0] sz, input logic [31:0] a);
    return (int'(a[1:0]) % nbytes(sz)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
    logic [3:0] be = '0;
    for (int i = 0; i < nbytes(sz); i++) be[int'(a[1:0]) + i] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % nbytes(sz)) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic uns,
                                         input logic [31:0] a, input logic [31:0] r);
    int     n = nbytes(sz);
    longint m = (longint'(1) << (8*n)) - 1;
    longint v = {32'd0, r};
    v = (v >> (8*int'(a[1:0]))) & m;
    if (!uns && v[8*n-1]) v = v | ~m;
    return v[31:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd, input logic rw,
                       input logic m2r, input logic [4:0] wreg);
    MemRead = rd; MemWrite = wr; MemSize = sz; LoadUnsigned = uns;
    ALUresult = a; writedata = wd; RegWrite = rw; MemtoReg = m2r; writeReg = wreg;
  endtask

  task automatic alu_op(input logic rw, input logic m2r, input logic [4:0] wreg,
                        input logic [31:0] res);
    drive(1'b0, 1'b0, 2'd2, 1'b0, res, 32'h0, rw, m2r, wreg);
    #1;
    chk("alu stall", 32'(stall), 32'd0);
    tick();
    chk("alu RegWriteOut", 32'(RegWriteOut), 32'(rw));
    chk("alu MemtoRegOut", 32'(MemtoRegOut), 32'(m2r));
    chk("alu writeRegOut", 32'(writeRegOut), 32'(wreg));
    chk("alu ALUresultOut", ALUresultOut, res);
    chk("alu readdata kept", readdataOut, exp_rd);
    chk("alu misalign", 32'(misalign), 32'd0);
  endtask

  task automatic access(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdata,
                        input logic rw, input logic m2r, input logic [4:0] wreg, input int nwait);
    logic is_load = rd & ~wr;
    drive(rd, wr, sz, uns, a, wd, rw, m2r, wreg);
    dmem_ack = 1'b0;
    #1;
    if (m_mis(sz, a)) begin
      chk("mis stall", 32'(stall), 32'd0);
      tick();
      chk("mis pulse", 32'(misalign), 32'd1);
      chk("mis no req", 32'(dmem_req), 32'd0);
      chk("mis RegWriteOut", 32'(RegWriteOut), 32'd0);
      chk("mis readdata kept", readdataOut, exp_rd);
      return;
    end
    chk("issue stall", 32'(stall), 32'd1);
    tick();
    chk("req", 32'(dmem_req), 32'd1);
    chk("we", 32'(dmem_we), 32'(wr));
    chk("addr", dmem_addr, {a[31:2], 2'b00});
    chk("be", 32'(dmem_be), 32'(m_be(sz, a)));
    if (wr) chk("wdata", dmem_wdata, m_wdata(sz, wd));
    chk("bubble RegWriteOut", 32'(RegWriteOut), 32'd0);
    chk("bubble MemtoRegOut", 32'(MemtoRegOut), 32'd0);
    chk("no misalign", 32'(misalign), 32'd0);
    for (int k = 0; k < nwait; k++) begin
      chk("wait stall", 32'(stall), 32'd1);
      tick();
      chk("wait req held", 32'(dmem_req), 32'd1);
      chk("wait be held", 32'(dmem_be), 32'(m_be(sz, a)));
      chk("wait bubble", 32'(RegWriteOut), 32'd0);
    end
    dmem_ack = 1'b1;
    dmem_rdata = rdata;
    #1;
    chk("ack stall", 32'(stall), 32'd0);
    tick();
    dmem_ack = 1'b0;
    dmem_rdata = $urandom;
    if (is_load) exp_rd = m_load(sz, uns, a, rdata);
    chk("done req", 32'(dmem_req), 32'd0);
    chk("done RegWriteOut", 32'(RegWriteOut), 32'(rw));
    chk("done MemtoRegOut", 32'(MemtoRegOut), 32'(m2r));
    chk("done writeRegOut", 32'(writeRegOut), 32'(wreg));
    chk("done ALUresultOut", ALUresultOut, a);
    chk("done readdataOut", readdataOut, exp_rd);
  endtask

  initial begin
    rst = 1'b1;
    dmem_ack = 1'b0;
    dmem_rdata = 32'h0;
    drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0);
    exp_rd = 32'h0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst req", 32'(dmem_req), 32'd0);
    chk("rst stall", 32'(stall), 32'd0);
    chk("rst misalign", 32'(misalign), 32'd0);
    chk("rst RegWriteOut", 32'(RegWriteOut), 32'd0);
    chk("rst readdataOut", readdataOut, 32'd0);
    chk("rst be", 32'(dmem_be), 32'd0);

    // word store, ack on the third stall cycle
    access(1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 5'd0, 2);
    // lb / lbu at 0x13
    access(1'b1, 1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 32'h80FFFF7F, 1'b1, 1'b1, 5'd8, 1);
    chk("lb literal", readdataOut, 32'hFFFFFF80);
    access(1'b1, 1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 32'h80FFFF7F, 1'b1, 1'b1, 5'd9, 0);
    chk("lbu literal", readdataOut, 32'h00000080);
    // sh at 0x22, then misaligned lw
    access(1'b0, 1'b1, 2'd1, 1'b0, 32'h22, 32'h00001234, 32'h0, 1'b0, 1'b0, 5'd0, 1);
    access(1'b1, 1'b0, 2'd2, 1'b0, 32'h22, 32'h0, 32'h0, 1'b1, 1'b1, 5'd3, 0);
    // load then ALU op right behind it
    access(1'b1, 1'b0, 2'd1, 1'b0, 32'h42, 32'h0, 32'h9ABC1234, 1'b1, 1'b1, 5'd4, 0);
    chk("lh literal", readdataOut, 32'hFFFF9ABC);
    alu_op(1'b1, 1'b0, 5'd5, 32'd7);
    // store wins over a simultaneous load
    access(1'b1, 1'b1, 2'd2, 1'b0, 32'h80, 32'h55AA55AA, 32'h11111111, 1'b0, 1'b0, 5'd0, 0);

    // reset while BUSY, then a late ack must be ignored
    drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 1'b1, 1'b1, 5'd6);
    tick();
    chk("pre-rst req", 32'(dmem_req), 32'd1);
    rst = 1'b1;
    drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0);
    tick();
    rst = 1'b0;
    exp_rd = 32'h0;
    chk("rst busy req", 32'(dmem_req), 32'd0);
    chk("rst busy stall", 32'(stall), 32'd0);
    chk("rst busy readdata", readdataOut, 32'd0);
    chk("rst busy ALUresultOut", ALUresultOut, 32'd0);
    dmem_ack = 1'b1;
    dmem_rdata = 32'hCAFEF00D;
    tick();
    dmem_ack = 1'b0;
    chk("late ack req", 32'(dmem_req), 32'd0);
    chk("late ack readdata", readdataOut, 32'd0);
    chk("late ack RegWriteOut", 32'(RegWriteOut), 32'd0);

    // random instruction stream
    for (int i = 0; i < 80; i++) begin
      int          kind = $urandom_range(0, 3);
      logic [1:0]  sz   = 2'($urandom_range(0, 3));
      logic [31:0] a    = $urandom;
      logic [4:0]  wr5  = 5'($urandom);
      logic        rw   = 1'($urandom);
      logic        m2r  = 1'($urandom);
      logic        uns  = 1'($urandom);
      int          nw   = $urandom_range(0, 3);
      case (kind)
        0: alu_op(rw, m2r, wr5, a);
        1: access(1'b1, 1'b0, sz, uns, a, $urandom, $urandom, rw, m2r, wr5, nw);
        2: access(1'b0, 1'b1, sz, uns, a, $urandom, $urandom, rw, m2r, wr5, nw);
        default: access(1'b1, 1'b1, sz, uns, a, $urandom, $urandom, rw, m2r, wr5, nw);
      endcase
    end
    alu_op(1'b0, 1'b0, 5'd0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
